// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-to-hazard-unit signal bundle
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_Rs1;
  logic [4:0]       IF_ID_Rs2;
  logic             ID_uses_rs1;
  logic             ID_uses_rs2;
  logic [4:0]       ID_EX_Rd;
  logic             ID_EX_MemRead;
  logic             EX_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_bubble;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output IF_ID_Rs1, IF_ID_Rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_Rd, ID_EX_MemRead,
           EX_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble,
           mem_timeout_err, load_use_cnt, mem_wait_cnt, flush_cnt
  );
  modport slave (
    input  IF_ID_Rs1, IF_ID_Rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_Rd, ID_EX_MemRead,
           EX_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble,
           mem_timeout_err, load_use_cnt, mem_wait_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, memory freeze and branch flush control with stall counters
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_control_unit_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t        state;
  logic [WW-1:0] wait_ctr;
  logic [WW-1:0] wait_base;
  logic          freeze;
  logic          flush;
  logic          load_use;
  logic          rs_match;
  assign freeze    = bus.mem_req && !bus.mem_ready;
  assign flush     = !freeze && bus.EX_branch_taken;
  assign rs_match  = (bus.ID_uses_rs1 && bus.ID_EX_Rd == bus.IF_ID_Rs1) ||
                     (bus.ID_uses_rs2 && bus.ID_EX_Rd == bus.IF_ID_Rs2);
  assign load_use  = !freeze && !bus.EX_branch_taken && bus.ID_EX_MemRead &&
                     bus.ID_EX_Rd != 5'd0 && rs_match;
  assign wait_base = state == MEM_WAIT ? wait_ctr : '0;
  // Priority-ordered pipeline controls; reset holds every output at its default
  always_comb begin
    bus.pc_write      = !(rst_n && (freeze || load_use));
    bus.if_id_write   = !(rst_n && (freeze || load_use));
    bus.ex_mem_write  = !(rst_n && freeze);
    bus.mem_wb_bubble = rst_n && freeze;
    bus.if_id_flush   = rst_n && flush;
    bus.id_ex_flush   = rst_n && (flush || load_use);
  end
  // Wait FSM, consecutive-freeze timer, sticky timeout flag and saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= RUN;
      wait_ctr            <= '0;
      bus.mem_timeout_err <= 1'b0;
      bus.load_use_cnt    <= '0;
      bus.mem_wait_cnt    <= '0;
      bus.flush_cnt       <= '0;
    end else begin
      state    <= freeze ? MEM_WAIT : RUN;
      wait_ctr <= !freeze ? '0 : wait_base == WW'(MEM_TIMEOUT) ? wait_base : wait_base + 1'b1;
      if (freeze && wait_base >= WW'(MEM_TIMEOUT - 1)) bus.mem_timeout_err <= 1'b1;
      if (load_use && ~&bus.load_use_cnt) bus.load_use_cnt <= bus.load_use_cnt + 1'b1;
      if (freeze && ~&bus.mem_wait_cnt) bus.mem_wait_cnt <= bus.mem_wait_cnt + 1'b1;
      if (flush && ~&bus.flush_cnt) bus.flush_cnt <= bus.flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed and random stimulus scored against a behavioural hazard model
module tb_hazard_control_unit;
  localparam int TO = 4;
  localparam int CW = 2;
  localparam int MX = (1 << CW) - 1;
  localparam logic [5:0] DEF = 6'b110010;
  typedef struct {
    logic [5:0] ctrl;
    logic       err;
    int         lu;
    int         mw;
    int         fl;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_lu = 0, m_mw = 0, m_fl = 0, m_run = 0;
  logic m_err = 1'b0;
  logic hold_req = 1'b0;
  hazard_control_unit_if #(.CNT_W(CW)) bus ();
  hazard_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic void chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction
  function automatic int sat(input int v);
    return v >= MX ? MX : v + 1;
  endfunction
  // One cycle: drive inputs, predict this cycle's response, then advance the model across the edge
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic u1, input logic u2, input logic mr, input logic br,
                      input logic mq, input logic mrdy);
    exp_t e;
    logic frz, lu;
    @(posedge clk);
    #1;
    rst_n = r;
    bus.IF_ID_Rs1 = rs1; bus.IF_ID_Rs2 = rs2; bus.ID_EX_Rd = rd;
    bus.ID_uses_rs1 = u1; bus.ID_uses_rs2 = u2; bus.ID_EX_MemRead = mr;
    bus.EX_branch_taken = br; bus.mem_req = mq; bus.mem_ready = mrdy;
    frz = mq && !mrdy;
    lu = mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
    e.ctrl = !r ? DEF : frz ? 6'b000001 : br ? 6'b111110 : lu ? 6'b000110 : DEF;
    e.err = m_err; e.lu = m_lu; e.mw = m_mw; e.fl = m_fl;
    q.push_back(e);
    if (!r) begin
      m_lu = 0; m_mw = 0; m_fl = 0; m_run = 0; m_err = 1'b0;
    end else begin
      if (frz) begin
        m_mw = sat(m_mw);
        m_run++;
        if (m_run >= TO) m_err = 1'b1;
      end else m_run = 0;
      if (!frz && br) m_fl = sat(m_fl);
      if (!frz && !br && lu) m_lu = sat(m_lu);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // Monitor: every cycle's outputs are compared against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("ctrl", int'({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
                          bus.ex_mem_write, bus.mem_wb_bubble}), int'(e.ctrl));
        chk("mem_timeout_err", int'(bus.mem_timeout_err), int'(e.err));
        chk("load_use_cnt", int'(bus.load_use_cnt), e.lu);
        chk("mem_wait_cnt", int'(bus.mem_wait_cnt), e.mw);
        chk("flush_cnt", int'(bus.flush_cnt), e.fl);
      end
    end
  end
  initial begin
    logic r, mq;
    bus.IF_ID_Rs1 = 0; bus.IF_ID_Rs2 = 0; bus.ID_EX_Rd = 0; bus.ID_uses_rs1 = 0;
    bus.ID_uses_rs2 = 0; bus.ID_EX_MemRead = 0; bus.EX_branch_taken = 0;
    bus.mem_req = 0; bus.mem_ready = 0;
    repeat (2) @(posedge clk);
    idle(2);
    step(1, 5, 0, 5, 1, 0, 1, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    step(1, 3, 7, 7, 1, 0, 1, 0, 0, 0);
    step(1, 7, 0, 7, 1, 0, 0, 0, 0, 0);
    step(1, 0, 9, 9, 0, 1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);
    repeat (6) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) step(1, 6, 0, 6, 1, 0, 1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 59) != 0;
      if (!hold_req) hold_req = $urandom_range(0, 3) == 0;
      mq = hold_req && $urandom_range(0, 15) != 0;
      step(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
           mq, $urandom_range(0, 4) == 0);
      if (bus.mem_req && bus.mem_ready) hold_req = 1'b0;
    end
    idle(2);
    @(posedge clk);
    @(posedge clk);
    chk("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
